// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard unit: operand forwarding, load-use/branch/memory-wait
// stall and flush control, plus stall and flush performance counters.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       RS1_D,
   input  logic [4:0]       RS2_D,
   input  logic [4:0]       RS1_E,
   input  logic [4:0]       RS2_E,
   input  logic [4:0]       RD_E,
   input  logic             ResultSrcE,
   input  logic [4:0]       RD_M,
   input  logic [4:0]       RD_W,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             PCSrcE,
   input  logic             mem_busy,
   input  logic             cnt_clr,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic [1:0]       hz_state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      LDSTALL = 2'b01,
      FLUSH   = 2'b10,
      MWAIT   = 2'b11
   } hz_state_t;

   hz_state_t state_q;
   hz_state_t state_d;
   logic      lw_hz;
   logic      lw_en;

   assign lw_hz    = ResultSrcE && (RD_E != 5'd0) && ((RD_E == RS1_D) || (RD_E == RS2_D));
   // Load-use only matters when the decode slot holds a fresh instruction.
   assign lw_en    = (state_q == RUN) || (state_q == MWAIT);
   assign hz_state = state_q;

   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (!rst) begin
         if (RegWriteM && (RD_M != 5'd0) && (RD_M == RS1_E))
            ForwardAE = 2'b10;
         else if (RegWriteW && (RD_W != 5'd0) && (RD_W == RS1_E))
            ForwardAE = 2'b01;
         if (RegWriteM && (RD_M != 5'd0) && (RD_M == RS2_E))
            ForwardBE = 2'b10;
         else if (RegWriteW && (RD_W != 5'd0) && (RD_W == RS2_E))
            ForwardBE = 2'b01;
      end
   end

   // MWAIT with memory ready falls through to the RUN rules in the same cycle.
   always_comb begin
      StallF  = 1'b0;
      StallD  = 1'b0;
      StallE  = 1'b0;
      StallM  = 1'b0;
      FlushD  = 1'b0;
      FlushE  = 1'b0;
      state_d = RUN;
      if (rst) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (mem_busy) begin
         StallF  = 1'b1;
         StallD  = 1'b1;
         StallE  = 1'b1;
         StallM  = 1'b1;
         state_d = MWAIT;
      end else if (PCSrcE) begin
         FlushD  = 1'b1;
         FlushE  = 1'b1;
         state_d = FLUSH;
      end else if (lw_hz && lw_en) begin
         StallF  = 1'b1;
         StallD  = 1'b1;
         FlushE  = 1'b1;
         state_d = LDSTALL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (StallF && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (state_d == FLUSH)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl: per-cycle reference model
// plus directed vectors with literal expectations.
module tb_hazard_ctrl;
   localparam int CW   = 12;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
   logic          ResultSrcE, RegWriteM, RegWriteW, PCSrcE, mem_busy, cnt_clr;
   logic          StallF, StallD, StallE, StallM, FlushD, FlushE;
   logic [1:0]    ForwardAE, ForwardBE, hz_state;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   hazard_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
      .ResultSrcE(ResultSrcE), .RD_M(RD_M), .RD_W(RD_W),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
      .mem_busy(mem_busy), .cnt_clr(cnt_clr),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .hz_state(hz_state),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int fwd(input logic [4:0] rs);
      if (RegWriteM && RD_M != 0 && RD_M == rs) return 2;
      if (RegWriteW && RD_W != 0 && RD_W == rs) return 1;
      return 0;
   endfunction

   // Reference model: mode 0 normal, 1 after load stall, 2 after branch, 3 waiting on memory.
   int m_mode = 0, m_stall = 0, m_flush = 0;
   int ev;
   bit lw, e_sf, e_se, e_fd, e_fe;
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         lw = ResultSrcE && RD_E != 0 && (RD_E == RS1_D || RD_E == RS2_D);
         if (rst) ev = 4;
         else if (mem_busy) ev = 1;
         else if (PCSrcE) ev = 2;
         else if (lw && (m_mode == 0 || m_mode == 3)) ev = 3;
         else ev = 0;
         e_sf = (ev == 1 || ev == 3);
         e_se = (ev == 1);
         e_fd = (ev == 2 || ev == 4);
         e_fe = (ev == 2 || ev == 3 || ev == 4);
         chk("m_stallf", StallF, e_sf);
         chk("m_stalld", StallD, e_sf);
         chk("m_stalle", StallE, e_se);
         chk("m_stallm", StallM, e_se);
         chk("m_flushd", FlushD, e_fd);
         chk("m_flushe", FlushE, e_fe);
         chk("m_fwda", ForwardAE, rst ? 0 : fwd(RS1_E));
         chk("m_fwdb", ForwardBE, rst ? 0 : fwd(RS2_E));
         chk("m_state", hz_state, m_mode);
         chk("m_stall_cnt", stall_cnt, m_stall);
         chk("m_flush_cnt", flush_cnt, m_flush);
         if (rst) begin
            m_mode = 0; m_stall = 0; m_flush = 0;
         end else begin
            m_mode = (ev == 1) ? 3 : (ev == 2) ? 2 : (ev == 3) ? 1 : 0;
            if (cnt_clr) begin
               m_stall = 0; m_flush = 0;
            end else begin
               if (e_sf && m_stall < CMAX) m_stall = m_stall + 1;
               if (ev == 2) m_flush = (m_flush + 1) % (CMAX + 1);
            end
         end
      end
   end

   task automatic idle();
      rst = 0; RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
      ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; mem_busy = 0; cnt_clr = 0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst = 1; RegWriteM = 1; RD_M = 3; RS1_E = 3;
      @(negedge clk);
      chk("rst_flushd", FlushD, 1);
      chk("rst_flushe", FlushE, 1);
      chk("rst_stallf", StallF, 0);
      chk("rst_fwda", ForwardAE, 0);
      nxt(); nxt();
      chk("rst_state", hz_state, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);

      idle(); RegWriteM = 1; RD_M = 3; RegWriteW = 1; RD_W = 3; RS1_E = 3; RS2_E = 3;
      @(negedge clk);
      chk("fwd_mem_a", ForwardAE, 2);
      chk("fwd_mem_b", ForwardBE, 2);
      nxt(); RegWriteM = 0;
      @(negedge clk);
      chk("fwd_wb_a", ForwardAE, 1);
      nxt(); RegWriteM = 1; RD_M = 0; RS1_E = 0; RD_W = 7; RS2_E = 7;
      @(negedge clk);
      chk("fwd_x0_a", ForwardAE, 0);
      chk("fwd_wb_b", ForwardBE, 1);

      nxt(); idle(); cnt_clr = 1;
      nxt(); cnt_clr = 0; ResultSrcE = 1; RD_E = 5; RS1_D = 5;
      @(negedge clk);
      chk("ld_stallf", StallF, 1);
      chk("ld_stalld", StallD, 1);
      chk("ld_flushe", FlushE, 1);
      nxt();
      chk("ld_state", hz_state, 1);
      @(negedge clk);
      chk("ld_masked", StallF, 0);
      nxt();
      chk("ld_back_run", hz_state, 0);
      chk("ld_stall_cnt", stall_cnt, 1);

      PCSrcE = 1;
      @(negedge clk);
      chk("br_flushd", FlushD, 1);
      chk("br_flushe", FlushE, 1);
      chk("br_stallf", StallF, 0);
      nxt();
      chk("br_state", hz_state, 2);
      chk("br_flush_cnt", flush_cnt, 1);

      idle(); cnt_clr = 1;
      nxt(); cnt_clr = 0; mem_busy = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mw_stall", {StallF, StallD, StallE, StallM}, 4'hF);
         nxt();
      end
      mem_busy = 0; PCSrcE = 1;
      @(negedge clk);
      chk("mw_drop_flushd", FlushD, 1);
      chk("mw_drop_flushe", FlushE, 1);
      chk("mw_drop_stallf", StallF, 0);
      nxt();
      chk("mw_stall_cnt", stall_cnt, 4);
      chk("mw_drop_state", hz_state, 2);

      idle(); mem_busy = 1;
      nxt(); nxt();
      chk("rw_in_mwait", hz_state, 3);
      rst = 1;
      @(negedge clk);
      chk("rw_rst_stallf", StallF, 0);
      chk("rw_rst_flushd", FlushD, 1);
      nxt();
      chk("rw_state_run", hz_state, 0);
      chk("rw_stall_cnt", stall_cnt, 0);
      chk("rw_flush_cnt", flush_cnt, 0);
      rst = 0;
      @(negedge clk);
      chk("rw_rebusy", StallF, 1);
      nxt();
      chk("rw_remwait", hz_state, 3);

      mem_busy = 0; ResultSrcE = 1; RD_E = 9; RS2_D = 9;
      @(negedge clk);
      chk("mw_ld_stallf", StallF, 1);
      chk("mw_ld_stallm", StallM, 0);
      nxt();
      chk("mw_ld_state", hz_state, 1);

      idle(); PCSrcE = 1;
      nxt(); PCSrcE = 0; ResultSrcE = 1; RD_E = 9; RS1_D = 9;
      @(negedge clk);
      chk("fl_ld_masked", StallF, 0);
      nxt();
      chk("fl_back_run", hz_state, 0);

      for (int i = 0; i < 300; i++) begin
         rst        = ($urandom_range(0, 40) == 0);
         cnt_clr    = ($urandom_range(0, 30) == 0);
         mem_busy   = ($urandom_range(0, 4) == 0);
         PCSrcE     = ($urandom_range(0, 4) == 0);
         ResultSrcE = $urandom_range(0, 1);
         RegWriteM  = $urandom_range(0, 1);
         RegWriteW  = $urandom_range(0, 1);
         RS1_D = 5'($urandom_range(0, 3)); RS2_D = 5'($urandom_range(0, 3));
         RS1_E = 5'($urandom_range(0, 3)); RS2_E = 5'($urandom_range(0, 3));
         RD_E  = 5'($urandom_range(0, 3)); RD_M  = 5'($urandom_range(0, 3));
         RD_W  = 5'($urandom_range(0, 3));
         nxt();
      end

      idle(); cnt_clr = 1;
      nxt(); cnt_clr = 0; mem_busy = 1;
      repeat (CMAX + 10) nxt();
      chk("sat_stall_cnt", stall_cnt, CMAX);
      cnt_clr = 1;
      @(negedge clk);
      chk("clr_during_stall", StallF, 1);
      nxt();
      chk("clr_stall_cnt", stall_cnt, 0);
      chk("clr_flush_cnt", flush_cnt, 0);
      cnt_clr = 0; mem_busy = 0; PCSrcE = 1;
      repeat (CMAX) nxt();
      chk("wrap_flush_max", flush_cnt, CMAX);
      nxt();
      chk("wrap_flush_zero", flush_cnt, 0);
      idle();
      nxt(); nxt();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
